// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - MIPS R-type opcode, func and ALUOp constants shared by encoder and decoder
package mips_pkg;

   localparam logic [5:0] OPCODE_RTYPE = 6'd0;

   localparam logic [5:0] FUNC_AND = 6'h24;
   localparam logic [5:0] FUNC_OR  = 6'h25;
   localparam logic [5:0] FUNC_ADD = 6'h20;
   localparam logic [5:0] FUNC_SUB = 6'h22;
   localparam logic [5:0] FUNC_SLT = 6'h2A;

   localparam logic [2:0] ALUOP_AND = 3'b000;
   localparam logic [2:0] ALUOP_OR  = 3'b001;
   localparam logic [2:0] ALUOP_ADD = 3'b010;
   localparam logic [2:0] ALUOP_SUB = 3'b110;
   localparam logic [2:0] ALUOP_SLT = 3'b111;

   function automatic logic aluop_legal(input logic [2:0] aluop);
      logic ok;
      ok = 1'b0;
      case (aluop)
         ALUOP_AND, ALUOP_OR, ALUOP_ADD, ALUOP_SUB, ALUOP_SLT: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [5:0] aluop_func(input logic [2:0] aluop);
      logic [5:0] f;
      f = 6'd0;
      case (aluop)
         ALUOP_AND: f = FUNC_AND;
         ALUOP_OR:  f = FUNC_OR;
         ALUOP_ADD: f = FUNC_ADD;
         ALUOP_SUB: f = FUNC_SUB;
         ALUOP_SLT: f = FUNC_SLT;
         default:   f = 6'd0;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - registered FIFO with read/write pointers and occupancy counter
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    occ;
   logic             do_push;
   logic             do_pop;

   // Guards here make the FIFO safe even if a caller ignores full/empty.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign full  = (occ == CW'(DEPTH));
   assign empty = (occ == '0);
   assign count = occ;
   assign rdata = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   occ <= occ + CW'(1);
            2'b01:   occ <= occ - CW'(1);
            default: occ <= occ;
         endcase
      end
   end

endmodule

// File: rtl/rtype_instr_encoder.sv
// rtl/rtype_instr_encoder.sv - encodes ALUOp requests into R-type words and streams them to imem
module rtype_instr_encoder
   import mips_pkg::*;
#(
   parameter int                DEPTH     = 4,
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_aluop,
   input  logic [4:0]        req_rs,
   input  logic [4:0]        req_rt,
   input  logic [4:0]        req_rd,
   output logic              imem_valid,
   input  logic              imem_ready,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic [ADDR_W-1:0] instr_count,
   output logic              illegal_op
);

   localparam int CW = $clog2(DEPTH) + 1;

   function automatic logic [31:0] encode(input logic [2:0] aluop, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd);
      return {OPCODE_RTYPE, rs, rt, rd, 5'd0, aluop_func(aluop)};
   endfunction

   logic          fifo_full;
   logic          fifo_empty;
   logic [31:0]   head;
   logic [31:0]   last_wdata;
   logic [CW-1:0] occ;
   logic          accept;
   logic          push;
   logic          pop;

   assign req_ready  = !fifo_full;
   assign imem_valid = (occ != '0);
   assign accept     = req_valid && req_ready;
   assign push       = accept && aluop_legal(req_aluop);
   assign pop        = imem_valid && imem_ready && !reset;

   // Once drained, keep showing the last word written rather than stale FIFO slots.
   assign imem_wdata = fifo_empty ? last_wdata : head;

   sync_fifo #(
      .WIDTH (32),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .wdata (encode(req_aluop, req_rs, req_rt, req_rd)),
      .pop   (pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (occ)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         imem_addr   <= BASE_ADDR;
         instr_count <= '0;
         last_wdata  <= '0;
         illegal_op  <= 1'b0;
      end else begin
         if (pop) begin
            imem_addr   <= imem_addr + ADDR_W'(4);
            instr_count <= instr_count + ADDR_W'(1);
            last_wdata  <= head;
         end
         if (accept && !aluop_legal(req_aluop)) begin
            illegal_op <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_rtype_instr_encoder.sv
// tb/tb_rtype_instr_encoder.sv - scoreboard bench for rtype_instr_encoder
module tb_rtype_instr_encoder;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic [2:0]  req_aluop;
   logic [4:0]  req_rs, req_rt, req_rd;
   logic        imem_ready;

   logic        req_ready, imem_valid, illegal_op;
   logic [31:0] imem_addr, imem_wdata, instr_count;

   logic        req_ready_w, imem_valid_w, illegal_op_w;
   logic [3:0]  imem_addr_w, instr_count_w;
   logic [31:0] imem_wdata_w;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [63:0] q1[$];
   logic [63:0] q2[$];
   logic [63:0] e1, e2;
   logic [31:0] exp_addr;
   logic [3:0]  exp_addr_w;
   logic [31:0] held;

   always #5 clk = ~clk;

   rtype_instr_encoder #(.DEPTH(4), .ADDR_W(32), .BASE_ADDR(32'd0)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_aluop(req_aluop), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
      .imem_valid(imem_valid), .imem_ready(imem_ready), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .instr_count(instr_count), .illegal_op(illegal_op)
   );

   rtype_instr_encoder #(.DEPTH(4), .ADDR_W(4), .BASE_ADDR(4'd12)) dut_w (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_w),
      .req_aluop(req_aluop), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
      .imem_valid(imem_valid_w), .imem_ready(imem_ready), .imem_addr(imem_addr_w),
      .imem_wdata(imem_wdata_w), .instr_count(instr_count_w), .illegal_op(illegal_op_w)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset === 1'b0 && imem_valid === 1'b1 && imem_ready === 1'b1) begin
         if (q1.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL extra_write: got addr %h data %h expected no write", imem_addr, imem_wdata);
         end else begin
            e1 = q1.pop_front();
            check("imem_addr", imem_addr, e1[63:32]);
            check("imem_wdata", imem_wdata, e1[31:0]);
         end
      end
   end

   always @(negedge clk) begin
      if (reset === 1'b0 && imem_valid_w === 1'b1 && imem_ready === 1'b1) begin
         if (q2.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL extra_write_w: got addr %h data %h expected no write", imem_addr_w, imem_wdata_w);
         end else begin
            e2 = q2.pop_front();
            check("imem_addr_w", {28'd0, imem_addr_w}, e2[63:32]);
            check("imem_wdata_w", imem_wdata_w, e2[31:0]);
         end
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      q1.delete();
      q2.delete();
      exp_addr = 32'd0;
      exp_addr_w = 4'd12;
   endtask

   task automatic send(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic legal, input logic [31:0] word);
      logic done;
      done = 1'b0;
      req_valid = 1'b1;
      req_aluop = op; req_rs = rs; req_rt = rt; req_rd = rd;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (req_ready) begin
            done = 1'b1;
            if (legal) begin
               q1.push_back({exp_addr, word});
               q2.push_back({28'd0, exp_addr_w, word});
               exp_addr = exp_addr + 32'd4;
               exp_addr_w = exp_addr_w + 4'd4;
            end
         end
         @(posedge clk);
         #1;
      end
      if (!done) begin
         n_cmp++; n_bad++;
         $display("FAIL send_timeout: got req_ready=0 expected 1 within 40 cycles");
      end
   endtask

   task automatic drain();
      logic done;
      done = 1'b0;
      req_valid = 1'b0;
      for (int i = 0; i < 60 && !done; i++) begin
         @(posedge clk);
         if (q1.size() == 0 && q2.size() == 0) done = 1'b1;
      end
      #1;
      if (!done) begin
         n_cmp++; n_bad++;
         $display("FAIL drain_timeout: got %0d words pending expected 0", q1.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200us");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_aluop = 3'd0;
      req_rs = 5'd0; req_rt = 5'd0; req_rd = 5'd0; imem_ready = 1'b0;
      do_reset();

      @(negedge clk);
      check("rst_req_ready", {31'd0, req_ready}, 32'd1);
      check("rst_imem_valid", {31'd0, imem_valid}, 32'd0);
      check("rst_imem_addr", imem_addr, 32'd0);
      check("rst_imem_wdata", imem_wdata, 32'd0);
      check("rst_instr_count", instr_count, 32'd0);
      check("rst_illegal_op", {31'd0, illegal_op}, 32'd0);
      check("rst_imem_addr_w", {28'd0, imem_addr_w}, 32'd12);
      @(posedge clk); #1;

      // single ADD, visible the cycle after the push
      imem_ready = 1'b1;
      send(3'b010, 5'd1, 5'd2, 5'd3, 1'b1, 32'h00221820);
      req_valid = 1'b0;
      @(negedge clk);
      check("add_valid", {31'd0, imem_valid}, 32'd1);
      check("add_wdata", imem_wdata, 32'h00221820);
      check("add_addr", imem_addr, 32'd0);
      drain();

      // back-to-back stream; the 4-bit instance wraps 12 -> 0
      do_reset();
      imem_ready = 1'b1;
      send(3'b110, 5'd5, 5'd6, 5'd4, 1'b1, 32'h00A62022);
      send(3'b111, 5'd9, 5'd10, 5'd8, 1'b1, 32'h012A402A);
      send(3'b000, 5'd2, 5'd3, 5'd1, 1'b1, 32'h00430824);
      send(3'b001, 5'd7, 5'd0, 5'd7, 1'b1, 32'h00E03825);
      drain();
      check("b2b_instr_count", instr_count, 32'd4);
      check("b2b_instr_count_w", {28'd0, instr_count_w}, 32'd4);
      check("b2b_hold_wdata", imem_wdata, 32'h00E03825);
      check("b2b_hold_addr", imem_addr, 32'd16);

      // fill with imem stalled, then drain
      do_reset();
      imem_ready = 1'b0;
      send(3'b010, 5'd1, 5'd2, 5'd3, 1'b1, 32'h00221820);
      send(3'b110, 5'd5, 5'd6, 5'd4, 1'b1, 32'h00A62022);
      send(3'b111, 5'd9, 5'd10, 5'd8, 1'b1, 32'h012A402A);
      send(3'b000, 5'd2, 5'd3, 5'd1, 1'b1, 32'h00430824);
      req_valid = 1'b0;
      @(negedge clk);
      check("full_req_ready", {31'd0, req_ready}, 32'd0);
      check("full_req_ready_w", {31'd0, req_ready_w}, 32'd0);
      held = imem_wdata;
      @(posedge clk); #1;
      @(negedge clk);
      check("stall_hold_wdata", imem_wdata, held);
      check("stall_head", imem_wdata, 32'h00221820);
      @(posedge clk); #1;
      imem_ready = 1'b1;
      send(3'b001, 5'd7, 5'd0, 5'd7, 1'b1, 32'h00E03825);
      drain();
      check("fill_instr_count", instr_count, 32'd5);

      // illegal ALUOp between two ADDs
      do_reset();
      imem_ready = 1'b1;
      send(3'b010, 5'd1, 5'd2, 5'd3, 1'b1, 32'h00221820);
      send(3'b011, 5'd4, 5'd5, 5'd6, 1'b0, 32'd0);
      send(3'b010, 5'd11, 5'd12, 5'd13, 1'b1, 32'h016C6820);
      drain();
      check("ill_instr_count", instr_count, 32'd2);
      check("ill_flag", {31'd0, illegal_op}, 32'd1);
      check("ill_flag_w", {31'd0, illegal_op_w}, 32'd1);
      repeat (3) @(posedge clk);
      #1;
      check("ill_sticky", {31'd0, illegal_op}, 32'd1);

      // reset pulsed with three words queued and imem ready at that edge
      do_reset();
      imem_ready = 1'b0;
      send(3'b010, 5'd1, 5'd2, 5'd3, 1'b1, 32'h00221820);
      send(3'b110, 5'd5, 5'd6, 5'd4, 1'b1, 32'h00A62022);
      send(3'b111, 5'd9, 5'd10, 5'd8, 1'b1, 32'h012A402A);
      imem_ready = 1'b1;
      do_reset();
      @(negedge clk);
      check("mid_rst_valid", {31'd0, imem_valid}, 32'd0);
      check("mid_rst_addr", imem_addr, 32'd0);
      check("mid_rst_count", instr_count, 32'd0);
      check("mid_rst_illegal", {31'd0, illegal_op}, 32'd0);
      check("mid_rst_addr_w", {28'd0, imem_addr_w}, 32'd12);
      @(posedge clk); #1;
      send(3'b110, 5'd5, 5'd6, 5'd4, 1'b1, 32'h00A62022);
      drain();
      check("post_rst_count", instr_count, 32'd1);

      check("q1_empty", q1.size(), 32'd0);
      check("q2_empty", q2.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
